mem_coalesce_splitter: RTL and testbench

// - Load/store-unit stage upstream of the write-data assembler and the memory request port.
// - Accepts one warp memory request: per-thread addresses, active mask, write data and access width.
// - Splits it into one request per distinct memory block, serially.
// - Each emitted request carries the block address, the mask of threads hitting that block,
//   and per-thread byte offsets within it. These offsets drive write-data/mask assembly.

---
 rtl/mem_coalesce_splitter_pkg.sv | 41 ++++
 rtl/mem_coalesce_splitter_block_matcher.sv | 36 +++
 rtl/mem_coalesce_splitter.sv | 105 ++++++++++
 tb/tb_mem_coalesce_splitter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_coalesce_splitter_pkg.sv
// Shared load/store types and helpers for the warp request splitter.
// Holds address/mask typedefs plus the leader-select and alignment helpers.
package mem_coalesce_splitter_pkg;

  localparam int unsigned AddressWidth   = 32;
  localparam int unsigned RegWidth       = 32;
  localparam int unsigned WarpWidth      = 4;
  localparam int unsigned BlockIdxBits   = 4;
  localparam int unsigned WriteWidthBits = 2;
  localparam int unsigned BlockAddrWidth = AddressWidth - BlockIdxBits;
  localparam int unsigned ThreadIdxBits  = (WarpWidth > 1) ? $clog2(WarpWidth) : 1;

  typedef logic [AddressWidth-1:0]   addr_t;
  typedef logic [BlockAddrWidth-1:0] block_addr_t;
  typedef logic [BlockIdxBits-1:0]   block_idx_t;
  typedef logic [WarpWidth-1:0]      act_mask_t;
  typedef logic [WriteWidthBits-1:0] write_width_t;
  typedef logic [3:0]                tag_t;
  typedef logic [ThreadIdxBits-1:0]  thread_idx_t;

  typedef logic [WarpWidth-1:0][AddressWidth-1:0] warp_addr_t;
  typedef logic [WarpWidth-1:0][RegWidth-1:0]     warp_data_t;
  typedef logic [WarpWidth-1:0][BlockIdxBits-1:0] warp_offs_t;

  // Trailing-zero count of the mask; an empty mask yields thread 0.
  function automatic thread_idx_t lowest_set(input act_mask_t m);
    thread_idx_t idx;
    idx = '0;
    for (int i = WarpWidth - 1; i >= 0; i--) begin
      if (m[i]) idx = thread_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic logic is_aligned(input addr_t a, input write_width_t w);
    addr_t lsb_mask;
    lsb_mask = ~(addr_t'('1) << w);
    return (a & lsb_mask) == '0;
  endfunction

endpackage

// File: rtl/mem_coalesce_splitter_block_matcher.sv
// Combinational block matcher: picks the lowest pending thread as leader and
// gathers every pending thread whose block address equals the leader's.
module mem_coalesce_splitter_block_matcher
  import mem_coalesce_splitter_pkg::*;
(
  input  act_mask_t   i_remaining,
  input  warp_addr_t  i_addr,
  output act_mask_t   o_match,
  output block_addr_t o_blk_addr,
  output logic        o_last
);

  block_addr_t [WarpWidth-1:0] w_blk_addr;
  thread_idx_t                 w_leader;

  always_comb begin
    for (int t = 0; t < WarpWidth; t++) begin
      w_blk_addr[t] = i_addr[t][AddressWidth-1:BlockIdxBits];
    end
  end

  assign w_leader = lowest_set(i_remaining);

  // An empty pending mask reports block address 0 so the empty-request block is deterministic.
  assign o_blk_addr = (i_remaining == '0) ? '0 : w_blk_addr[w_leader];

  always_comb begin
    o_match = '0;
    for (int t = 0; t < WarpWidth; t++) begin
      o_match[t] = i_remaining[t] && (w_blk_addr[t] == o_blk_addr);
    end
  end

  assign o_last = (i_remaining & ~o_match) == '0;

endmodule

// File: rtl/mem_coalesce_splitter.sv
// Splits one warp memory request into serial per-block requests, one block per
// cycle, with a no-bubble hand-over to the next warp request on the last block.
module mem_coalesce_splitter
  import mem_coalesce_splitter_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  tag_t         req_tag_i,
  input  act_mask_t    req_act_mask_i,
  input  warp_addr_t   req_addr_i,
  input  warp_data_t   req_wdata_i,
  input  write_width_t req_width_i,
  output logic         blk_valid_o,
  input  logic         blk_ready_i,
  output tag_t         blk_tag_o,
  output block_addr_t  blk_addr_o,
  output act_mask_t    blk_mask_o,
  output warp_offs_t   blk_offsets_o,
  output warp_data_t   blk_wdata_o,
  output write_width_t blk_width_o,
  output logic         blk_last_o
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSplit = 1'b1;

  logic [0:0]   r_state;
  act_mask_t    r_remaining;
  tag_t         r_tag;
  warp_addr_t   r_addr;
  warp_data_t   r_wdata;
  write_width_t r_width;

  act_mask_t    w_match;
  block_addr_t  w_blk_addr;
  logic         w_last;
  logic         w_req_hs;
  logic         w_blk_hs;

  mem_coalesce_splitter_block_matcher u_matcher (
    .i_remaining (r_remaining),
    .i_addr      (r_addr),
    .o_match     (w_match),
    .o_blk_addr  (w_blk_addr),
    .o_last      (w_last)
  );

  assign blk_valid_o = (r_state == StSplit);
  assign blk_last_o  = blk_valid_o && w_last;
  assign blk_mask_o  = w_match;
  assign blk_addr_o  = w_blk_addr;
  assign blk_tag_o   = r_tag;
  assign blk_wdata_o = r_wdata;
  assign blk_width_o = r_width;

  always_comb begin
    for (int t = 0; t < WarpWidth; t++) begin
      blk_offsets_o[t] = r_addr[t][BlockIdxBits-1:0];
    end
  end

  assign w_blk_hs    = blk_valid_o && blk_ready_i;
  // Accepting on the last-block handshake lets the next request start without a bubble.
  assign req_ready_o = (r_state == StIdle) || (w_blk_hs && blk_last_o);
  assign w_req_hs    = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_remaining <= '0;
      r_tag       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_width     <= '0;
    end else if (w_req_hs) begin
      r_state     <= StSplit;
      r_remaining <= req_act_mask_i;
      r_tag       <= req_tag_i;
      r_addr      <= req_addr_i;
      r_wdata     <= req_wdata_i;
      r_width     <= req_width_i;
    end else if (w_blk_hs) begin
      r_remaining <= r_remaining & ~w_match;
      if (blk_last_o) r_state <= StIdle;
    end
  end

`ifndef SYNTHESIS
  logic w_req_aligned;

  always_comb begin
    w_req_aligned = 1'b1;
    for (int t = 0; t < WarpWidth; t++) begin
      if (req_act_mask_i[t] && !is_aligned(req_addr_i[t], req_width_i)) w_req_aligned = 1'b0;
    end
  end

  a_req_aligned : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_req_hs |-> w_req_aligned)
    else $error("misaligned warp request accepted");
`endif

endmodule

// File: tb/tb_mem_coalesce_splitter.sv
// Randomized bench for mem_coalesce_splitter with a block-list reference model
// and a scoreboard checked on every falling clock edge.
module tb_mem_coalesce_splitter;
  import mem_coalesce_splitter_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b1;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  tag_t         req_tag_i = '0;
  act_mask_t    req_act_mask_i = '0;
  warp_addr_t   req_addr_i = '0;
  warp_data_t   req_wdata_i = '0;
  write_width_t req_width_i = '0;
  logic         blk_valid_o;
  logic         blk_ready_i = 1'b1;
  tag_t         blk_tag_o;
  block_addr_t  blk_addr_o;
  act_mask_t    blk_mask_o;
  warp_offs_t   blk_offsets_o;
  warp_data_t   blk_wdata_o;
  write_width_t blk_width_o;
  logic         blk_last_o;

  mem_coalesce_splitter dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_tag_i      (req_tag_i),
    .req_act_mask_i (req_act_mask_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_width_i    (req_width_i),
    .blk_valid_o    (blk_valid_o),
    .blk_ready_i    (blk_ready_i),
    .blk_tag_o      (blk_tag_o),
    .blk_addr_o     (blk_addr_o),
    .blk_mask_o     (blk_mask_o),
    .blk_offsets_o  (blk_offsets_o),
    .blk_wdata_o    (blk_wdata_o),
    .blk_width_o    (blk_width_o),
    .blk_last_o     (blk_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    tag_t         tag;
    block_addr_t  addr;
    act_mask_t    mask;
    warp_offs_t   offs;
    warp_data_t   wdata;
    write_width_t width;
    logic         last;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: walk threads in ascending order; each still-unserved active
  // thread opens a block that takes every unserved active thread in that block.
  function automatic void push_req(input tag_t tag, input act_mask_t m, input warp_addr_t a,
                                   input warp_data_t d, input write_width_t w);
    exp_t      e;
    act_mask_t left;
    e.tag   = tag;
    e.wdata = d;
    e.width = w;
    for (int t = 0; t < WarpWidth; t++) e.offs[t] = a[t][BlockIdxBits-1:0];
    left = m;
    if (m == '0) begin
      e.addr = '0;
      e.mask = '0;
      e.last = 1'b1;
      q.push_back(e);
    end
    while (left != '0) begin
      int lead;
      lead = 0;
      for (int t = WarpWidth - 1; t >= 0; t--) if (left[t]) lead = t;
      e.addr = block_addr_t'(a[lead] >> BlockIdxBits);
      e.mask = '0;
      for (int t = 0; t < WarpWidth; t++) begin
        if (left[t] && ((a[t] >> BlockIdxBits) == (a[lead] >> BlockIdxBits))) e.mask[t] = 1'b1;
      end
      left   = left & ~e.mask;
      e.last = (left == '0);
      q.push_back(e);
    end
  endfunction

  logic [182:0] snap;
  logic [182:0] prev_snap;
  logic         prev_stall = 1'b0;
  assign snap = {blk_tag_o, blk_addr_o, blk_mask_o, blk_offsets_o, blk_wdata_o, blk_width_o, blk_last_o};

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("blk_valid", 256'(blk_valid_o), 256'(q.size() != 0));
      if (q.size() == 0) chk("req_ready_idle", 256'(req_ready_o), 256'(1));
      else chk("req_ready_busy", 256'(req_ready_o), 256'(q[0].last && blk_ready_i));
      if (prev_stall) chk("stall_hold", 256'(snap), 256'(prev_snap));
      if (q.size() != 0) begin
        chk("blk_tag",   256'(blk_tag_o),     256'(q[0].tag));
        chk("blk_addr",  256'(blk_addr_o),    256'(q[0].addr));
        chk("blk_mask",  256'(blk_mask_o),    256'(q[0].mask));
        chk("blk_offs",  256'(blk_offsets_o), 256'(q[0].offs));
        chk("blk_wdata", 256'(blk_wdata_o),   256'(q[0].wdata));
        chk("blk_width", 256'(blk_width_o),   256'(q[0].width));
        chk("blk_last",  256'(blk_last_o),    256'(q[0].last));
      end
      prev_stall = blk_valid_o && !blk_ready_i;
      prev_snap  = snap;
      if (blk_valid_o && blk_ready_i && q.size() != 0) void'(q.pop_front());
      if (req_valid_i && req_ready_o)
        push_req(req_tag_i, req_act_mask_i, req_addr_i, req_wdata_i, req_width_i);
    end
  end

  int stall_req_id = 0;
  int stall_len = 0;
  int seen_id = 0;
  int stall_cnt = 0;
  bit rand_rdy = 1'b0;

  always @(posedge clk_i) begin
    #2;
    if (stall_req_id != seen_id) begin
      seen_id   = stall_req_id;
      stall_cnt = stall_len;
    end
    if (stall_cnt > 0) begin
      blk_ready_i = 1'b0;
      stall_cnt--;
    end else if (rand_rdy) begin
      blk_ready_i = ($urandom_range(0, 3) != 0);
    end else begin
      blk_ready_i = 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send(input tag_t tag, input act_mask_t m, input warp_addr_t a,
                      input warp_data_t d, input write_width_t w);
    int n;
    n = 0;
    req_valid_i    = 1'b1;
    req_tag_i      = tag;
    req_act_mask_i = m;
    req_addr_i     = a;
    req_wdata_i    = d;
    req_width_i    = w;
    @(negedge clk_i);
    while (!req_ready_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    chk("req_accept", 256'(req_ready_o), 256'(1));
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      n++;
      @(posedge clk_i);
      #2;
    end
    chk("drain", 256'(q.size()), 256'(0));
    @(posedge clk_i);
    #1;
  endtask

  function automatic warp_addr_t rand_addrs(input write_width_t w);
    warp_addr_t a;
    for (int t = 0; t < WarpWidth; t++) begin
      block_addr_t b;
      block_idx_t  o;
      b = block_addr_t'(28'h40 + 28'($urandom_range(0, 3)));
      o = block_idx_t'($urandom_range(0, 15));
      o = (o >> w) << w;
      a[t] = {b, o};
    end
    return a;
  endfunction

  function automatic warp_data_t rand_data();
    warp_data_t d;
    for (int t = 0; t < WarpWidth; t++) d[t] = $urandom;
    return d;
  endfunction

  warp_addr_t a_unit;
  warp_addr_t a_scat;
  warp_addr_t a_part;

  initial begin
    a_unit = {32'h10C, 32'h108, 32'h104, 32'h100};
    a_scat = {32'h300, 32'h104, 32'h200, 32'h100};
    a_part = {32'h500, 32'h208, 32'h440, 32'h380};

    #2 rst_ni = 1'b0;
    #2;
    chk("rst_blk_valid", 256'(blk_valid_o), 256'(0));
    chk("rst_blk_last",  256'(blk_last_o),  256'(0));
    chk("rst_blk_mask",  256'(blk_mask_o),  256'(0));
    chk("rst_blk_wdata", 256'(blk_wdata_o), 256'(0));
    chk("rst_req_ready", 256'(req_ready_o), 256'(1));
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    send(4'h1, 4'b1111, a_unit, rand_data(), 2'd2);
    wait_drain();
    send(4'h2, 4'b1111, a_scat, rand_data(), 2'd2);
    wait_drain();
    send(4'h3, 4'b0100, a_part, rand_data(), 2'd2);
    send(4'h4, 4'b0000, a_part, rand_data(), 2'd2);
    wait_drain();

    // Three-cycle stall on the second scatter block.
    send(4'h5, 4'b1111, a_scat, rand_data(), 2'd2);
    @(posedge clk_i);
    #1;
    stall_len = 3;
    stall_req_id++;
    wait_drain();

    // Second request held valid while the first drains.
    send(4'h6, 4'b1111, a_scat, rand_data(), 2'd2);
    send(4'h7, 4'b1111, a_unit, rand_data(), 2'd2);
    wait_drain();

    // Reset while the second scatter block is on the output.
    send(4'h8, 4'b1111, a_scat, rand_data(), 2'd2);
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    chk("midrst_blk_valid", 256'(blk_valid_o), 256'(0));
    chk("midrst_blk_last",  256'(blk_last_o),  256'(0));
    chk("midrst_blk_mask",  256'(blk_mask_o),  256'(0));
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    chk("postrst_req_ready", 256'(req_ready_o), 256'(1));
    chk("postrst_blk_valid", 256'(blk_valid_o), 256'(0));
    @(posedge clk_i);
    #1;

    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      write_width_t w;
      w = write_width_t'($urandom_range(0, 3));
      send(tag_t'($urandom_range(0, 15)), act_mask_t'($urandom_range(0, 15)),
           rand_addrs(w), rand_data(), w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i);
        #1;
      end
    end
    wait_drain();
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
